// File: rtl/operand_sequencer.sv
// Feeds buffered A/B operand pairs to a start/done compute core, one operation
// at a time, and returns each result (or a timeout abort) through a valid/ready register.
module operand_sequencer #(
  parameter int unsigned SIZE    = 16,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [SIZE-1:0]            in_a_i,
  input  logic [SIZE-1:0]            in_b_i,
  output logic                       core_rst_begin_o,
  output logic                       core_start_o,
  output logic [SIZE-1:0]            core_a_o,
  output logic [SIZE-1:0]            core_b_o,
  input  logic                       core_done_i,
  input  logic [SIZE-1:0]            core_out_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [SIZE-1:0]            out_data_o,
  output logic                       out_err_o,
  output logic                       busy_o,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_START, S_WAIT, S_HOLD} state_e;

  state_e          state_q;
  logic [SIZE-1:0] mem_a_q [DEPTH];
  logic [SIZE-1:0] mem_b_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [TW-1:0]   tmo_q;
  logic            core_rst_begin_q, core_start_q, busy_q;
  logic            out_valid_q, out_err_q;
  logic [SIZE-1:0] core_a_q, core_b_q, out_data_q;
  logic            push, pop;

  assign in_ready_o = (count_q != FULL);
  assign push       = in_valid_i && in_ready_o;
  // Pop is tied to the IDLE->CLEAR transition; count_q is registered, so no bypass.
  assign pop        = (state_q == S_IDLE) && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q] <= in_a_i;
      mem_b_q[wr_ptr_q] <= in_b_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      tmo_q            <= '0;
      core_rst_begin_q <= 1'b0;
      core_start_q     <= 1'b0;
      busy_q           <= 1'b0;
      out_valid_q      <= 1'b0;
      out_err_q        <= 1'b0;
      out_data_q       <= '0;
      core_a_q         <= '0;
      core_b_q         <= '0;
    end else begin
      core_rst_begin_q <= 1'b0;
      core_start_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            state_q          <= S_CLEAR;
            core_rst_begin_q <= 1'b1;
            busy_q           <= 1'b1;
            core_a_q         <= mem_a_q[rd_ptr_q];
            core_b_q         <= mem_b_q[rd_ptr_q];
          end
        end
        S_CLEAR: begin
          state_q      <= S_START;
          core_start_q <= 1'b1;
        end
        S_START: begin
          state_q <= S_WAIT;
          tmo_q   <= '0;
        end
        S_WAIT: begin
          tmo_q <= tmo_q + TW'(1);
          // A completion on the expiry cycle still counts as a real result.
          if (core_done_i) begin
            state_q     <= S_HOLD;
            out_valid_q <= 1'b1;
            out_data_q  <= core_out_i;
            out_err_q   <= 1'b0;
          end else if (tmo_q == TLAST) begin
            state_q     <= S_HOLD;
            out_valid_q <= 1'b1;
            out_data_q  <= '0;
            out_err_q   <= 1'b1;
          end
        end
        S_HOLD: begin
          if (out_ready_i) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign core_rst_begin_o = core_rst_begin_q;
  assign core_start_o     = core_start_q;
  assign core_a_o         = core_a_q;
  assign core_b_o         = core_b_q;
  assign out_valid_o      = out_valid_q;
  assign out_data_o       = out_data_q;
  assign out_err_o        = out_err_q;
  assign busy_o           = busy_q;
  assign fifo_count_o     = count_q;

endmodule
